// File: rtl/knn_pkg.sv
// knn_pkg: shared FSM encoding, word count and coordinate word indices for knn_core
package knn_pkg;
  localparam int NUM_WORDS = 4;
  localparam int CNT_W = 2;
  localparam logic [CNT_W-1:0] IDX_AX = 2'd0;
  localparam logic [CNT_W-1:0] IDX_BX = 2'd1;
  localparam logic [CNT_W-1:0] IDX_AY = 2'd2;
  localparam logic [CNT_W-1:0] IDX_BY = 2'd3;
  typedef enum logic [2:0] {IDLE, ARM1, ARM2, LOAD, COMPUTE, DONE} state_t;
endpackage

// File: rtl/knn_sqdiff.sv
// knn_sqdiff: squared unsigned absolute difference, truncated to DATA_W
module knn_sqdiff #(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] sq
);
  logic [DATA_W-1:0] d;
  assign d = a > b ? a - b : b - a;
  assign sq = d * d;
endmodule

// File: rtl/knn_core.sv
// knn_core: 2-D squared-distance engine; loads Ax,Bx,Ay,By serially, samples result on KNN_SAMPLE.
// Optional KNN_DONE output when KNN_DONE_EN is defined.
module knn_core
  import knn_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              KNN_ENABLE,
  input  logic              KNN_SAMPLE,
  input  logic [DATA_W-1:0] KNN_DATA_IN,
`ifdef KNN_DONE_EN
  output logic              KNN_DONE,
`else
`endif
  output logic [DATA_W-1:0] KNN_VALUE
);
  state_t state, next;
  logic [CNT_W-1:0] cnt;
  logic [NUM_WORDS-1:0][DATA_W-1:0] coord;
  logic [DATA_W-1:0] result, sq_x, sq_y;
  logic cap;
  knn_sqdiff #(.DATA_W(DATA_W)) u_sq_x (.a(coord[IDX_AX]), .b(coord[IDX_BX]), .sq(sq_x));
  knn_sqdiff #(.DATA_W(DATA_W)) u_sq_y (.a(coord[IDX_AY]), .b(coord[IDX_BY]), .sq(sq_y));
  // ARM2's outgoing edge is already the first capture, so the counter is 0 there
  assign cap = KNN_ENABLE && (state == ARM2 || state == LOAD);
  always_comb begin
    next = state;
    if (!KNN_ENABLE) next = IDLE;
    else
      case (state)
        IDLE:    next = ARM1;
        ARM1:    next = ARM2;
        ARM2:    next = LOAD;
        LOAD:    next = cnt == IDX_BY ? COMPUTE : LOAD;
        COMPUTE: next = DONE;
        default: next = state;
      endcase
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state     <= IDLE;
      cnt       <= '0;
      coord     <= '0;
      result    <= '0;
      KNN_VALUE <= '0;
    end else begin
      state <= next;
      cnt   <= state == IDLE ? '0 : cap ? cnt + 1'b1 : cnt;
      if (cap) coord[cnt] <= KNN_DATA_IN;
      if (state == COMPUTE && KNN_ENABLE) result <= sq_x + sq_y;
      if (KNN_SAMPLE) KNN_VALUE <= result;
    end
`ifdef KNN_DONE_EN
  always_ff @(posedge clk or negedge rst)
    if (!rst) KNN_DONE <= 1'b0;
    else KNN_DONE <= next == DONE && (state == COMPUTE || (KNN_DONE && !KNN_SAMPLE));
`endif
endmodule

// File: tb/tb_knn_core.sv
// tb_knn_core: directed runs on 32- and 16-bit knn_core against an edge-count model; KNN_DONE checked when KNN_DONE_EN is defined
module tb_knn_core;
  logic clk = 1'b0, rst = 1'b0, en = 1'b0, smp = 1'b0;
  logic [31:0] din = '0;
  logic [31:0] value;
  logic [15:0] value16;
  logic done, done16;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;

  knn_core #(.DATA_W(32)) dut (
    .clk(clk), .rst(rst), .KNN_ENABLE(en), .KNN_SAMPLE(smp), .KNN_DATA_IN(din),
`ifdef KNN_DONE_EN
    .KNN_DONE(done),
`endif
    .KNN_VALUE(value));
  knn_core #(.DATA_W(16)) dut16 (
    .clk(clk), .rst(rst), .KNN_ENABLE(en), .KNN_SAMPLE(smp), .KNN_DATA_IN(din[15:0]),
`ifdef KNN_DONE_EN
    .KNN_DONE(done16),
`endif
    .KNN_VALUE(value16));
`ifndef KNN_DONE_EN
  assign done = 1'b0;
  assign done16 = 1'b0;
`endif

  // Model: k counts consecutive edges with ENABLE high; edges 3..6 capture, edge 7 computes.
  int k = 0;
  logic [31:0] c [4] = '{default: '0};
  logic [31:0] m_res = '0, m_val = '0;
  logic [15:0] m_res16 = '0, m_val16 = '0;
  logic m_done = 1'b0;

  function automatic longint unsigned sqd(longint unsigned a, longint unsigned b);
    longint unsigned d;
    d = a > b ? a - b : b - a;
    return d * d;
  endfunction

  always @(posedge clk or negedge rst)
    if (!rst) begin
      k = 0; c = '{default: '0}; m_res = '0; m_val = '0; m_res16 = '0; m_val16 = '0; m_done = 1'b0;
    end else begin
      if (smp) begin m_val = m_res; m_val16 = m_res16; end
      if (en) begin
        k = k < 8 ? k + 1 : 8;
        if (k >= 3 && k <= 6) c[k-3] = din;
        if (k == 7) begin
          m_res   = 32'(sqd(c[0], c[1]) + sqd(c[2], c[3]));
          m_res16 = 16'(sqd(c[0][15:0], c[1][15:0]) + sqd(c[2][15:0], c[3][15:0]));
        end
        m_done = k == 7 ? 1'b1 : m_done && !smp;
      end else begin
        k = 0; m_done = 1'b0;
      end
    end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (rst) begin
      chk("value32", 64'(value), 64'(m_val));
      chk("value16", 64'(value16), 64'(m_val16));
`ifdef KNN_DONE_EN
      chk("done32", 64'(done), 64'(m_done));
      chk("done16", 64'(done16), 64'(m_done));
`else
      chk("no_done_model", 64'(m_done && !en), 64'd0);
`endif
    end
  end

  task automatic run(input logic [31:0] w0, w1, w2, w3, w4, w5);
    @(negedge clk); en = 1'b1; din = w0;
    @(negedge clk); din = w1;
    @(negedge clk); din = w2;
    @(negedge clk); din = w3;
    @(negedge clk); din = w4;
    @(negedge clk); din = w5;
  endtask

  task automatic pulse;
    @(negedge clk); smp = 1'b1;
    @(negedge clk); smp = 1'b0;
  endtask

  task automatic idle(input int n);
    @(negedge clk); en = 1'b0; din = '0;
    repeat (n) @(negedge clk);
  endtask

  task automatic expect_val(input string nm, input logic [31:0] v32, input logic [15:0] v16);
    chk({nm, "_model32"}, 64'(m_val), 64'(v32));
    chk({nm, "_dut32"}, 64'(value), 64'(v32));
    chk({nm, "_model16"}, 64'(m_val16), 64'(v16));
    chk({nm, "_dut16"}, 64'(value16), 64'(v16));
  endtask

  initial begin
    repeat (7) @(negedge clk);
    chk("reset_value", 64'(value), 64'd0);
    rst = 1'b1;
    pulse();
    expect_val("reset", 32'd0, 16'd0);
    // Nominal: first capture is the third enabled edge, giving words 3,2,1,1
    run(0, 4, 3, 2, 1, 1);
    repeat (1000) @(negedge clk);
`ifdef KNN_DONE_EN
    chk("done_held", 64'(done), 64'd1);
`else
`endif
    pulse();
    expect_val("nominal", 32'd1, 16'd1);
`ifdef KNN_DONE_EN
    chk("done_cleared", 64'(done), 64'd0);
`else
`endif
    idle(2);
    run(0, 0, 10, 7, 1, 5);
    repeat (3) @(negedge clk);
    pulse();
    expect_val("clean", 32'd25, 16'd25);
    idle(2);
    // Abort after two loaded words leaves the result untouched
    @(negedge clk); en = 1'b1; din = 0;
    @(negedge clk); din = 0;
    @(negedge clk); din = 8;
    @(negedge clk); din = 9;
    idle(2);
    pulse();
    expect_val("abort", 32'd25, 16'd25);
    run(0, 0, 0, 6, 2, 2);
    repeat (3) @(negedge clk);
    pulse();
    expect_val("rerun", 32'd36, 16'd36);
    idle(2);
    run(0, 0, 0, 300, 0, 0);
    repeat (3) @(negedge clk);
    pulse();
    expect_val("wrap", 32'd90000, 16'd24464);
    idle(2);
    // SAMPLE on the COMPUTE edge must see the previous result
    run(0, 0, 1, 4, 0, 0);
    pulse();
    expect_val("sample_compute_edge", 32'd90000, 16'd24464);
`ifdef KNN_DONE_EN
    chk("done_on_entry", 64'(done), 64'd1);
`else
`endif
    pulse();
    expect_val("sample_after", 32'd9, 16'd9);
`ifdef KNN_DONE_EN
    chk("done_after_sample", 64'(done), 64'd0);
`else
`endif
    idle(2);
    // Async reset mid-run clears the sampled value immediately
    run(0, 0, 5, 0, 0, 0);
    #2 rst = 1'b0;
    #1 chk("async_reset", 64'(value), 64'd0);
    en = 1'b0;
    @(negedge clk); rst = 1'b1;
    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
